feeder_loader: RTL and testbench
================================

Name: feeder_loader

Overview:
- Upstream stage of `data_feeder`.
- Accepts a byte stream over a valid/ready handshake and packs every 7 bytes into a 56-bit burst.
- Drives `data_feeder` with a one-cycle load pulse, the held 56-bit word, and a spaced train of shift-enable pulses.
- Double-buffered: the next burst is collected while the current one is being shifted out.

Parameters:
- BYTES, 7: bytes per burst. `feed_data` width is BYTES*8.
- SHIFTS, 6: number of `feed_enable` pulses issued after each load.
- GAP, 1: idle cycles after each `feed_enable` pulse; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  block can accept a byte; equals (pack_cnt < BYTES).
- in_data  in  8  input byte.
- flush  in  1  one-cycle pulse: close a partial burst, zero-padded.
- feed_load  out  1  one-cycle pulse; connects to the load (reset) pin of `data_feeder`.
- feed_data  out  56  burst word; held stable from a load until the next load.
- feed_enable  out  1  shift-enable to `data_feeder`.
- busy  out  1  high in LOAD, SHIFT, GAP and DONE.
- burst_done  out  1  one-cycle pulse after the last shift's gap.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; pack register and pack_cnt clear to 0.
  - `feed_data` = 0; `feed_load`, `feed_enable`, `busy` and `burst_done` = 0.
  - `in_ready` = 1, since it is derived from pack_cnt = 0.
  - Reset asserted mid-burst aborts immediately; no `burst_done` is produced.
- Packing:
  - A byte transfers on a rising edge when in_valid && in_ready.
  - First byte of a burst goes to pack[55:48], the next to [47:40], and so on; the 7th goes to [7:0].
  - pack_cnt increments on each transfer; when pack_cnt = BYTES the pack is full and `in_ready` = 0.
- Flush:
  - When flush=1 and pack_cnt is 1..6, the pack is marked full, with unfilled low bytes = 0x00.
  - If a byte transfers in the same cycle as flush, that byte is counted first, then padding is applied.
  - flush with pack_cnt = 0 and no transfer is ignored.
  - flush with the pack already full is ignored.
- FSM states: IDLE, LOAD, SHIFT, GAP, DONE. All outputs except `in_ready` are registered.
  - IDLE: if the pack is full, on the edge copy pack to `feed_data`, clear pack and pack_cnt, and go to LOAD.
  - LOAD: `feed_load` = 1 for exactly one cycle; set shift_cnt = 0; go to SHIFT.
  - SHIFT: `feed_enable` = 1 for one cycle; shift_cnt++.
    - If GAP > 0, go to GAP.
    - Else, if shift_cnt = SHIFTS, go to DONE; otherwise stay in SHIFT.
  - GAP: `feed_enable` = 0 for GAP cycles (gap counter). Then go to DONE if shift_cnt = SHIFTS, else back to SHIFT.
  - DONE: `burst_done` = 1 for one cycle. On the edge, if the pack is full, perform the IDLE transfer directly and go to LOAD; otherwise go to IDLE.
- Latency, with the last byte accepted at edge E0:
  - The FSM is in IDLE.
  - `feed_load` is high during E1–E2.
  - The k-th `feed_enable` (k = 0..SHIFTS-1) is high during E(2+k*(1+GAP)) to the following edge.
  - `burst_done` is high during E(2+SHIFTS*(1+GAP)) to the following edge.
  - With defaults, `burst_done` is high during E14–E15.
- Pack/unpack boundary: the pack clears on the transfer edge. `in_ready` is 0 during that cycle, so a byte can never be lost or double-written.
- Shift-count guard: `feed_enable` is never asserted when shift_cnt ≥ SHIFTS.
- Shift-count width: shift_cnt is $clog2(SHIFTS+1) bits.

Decomposition:
- Shared package `feeder_pkg` holds:
  - the state enum `feeder_state_e` {IDLE, LOAD, SHIFT, GAP, DONE};
  - localparams BYTE_W = 8 and BURST_W = BYTES*BYTE_W.
- One sub-module, `byte_packer`, owns:
  - the pack register, pack_cnt, flush padding, the full flag and `in_ready`;
  - a `take` input that clears it.
- `feeder_loader` owns the FSM and the `feed_*` outputs.

Test Plan:
- Single burst: send 0x11, 0x22, 0x33, 0x44, 0x55, 0x66, 0x77 back-to-back.
  - Expect `feed_data` = 0x11223344556677 and `feed_load` high during E1–E2.
  - Expect `feed_enable` high at E2, E4, E6, E8, E10, E12.
  - Expect `burst_done` high at E14.
- Overlap: during burst 1, stream 0xA1, 0xB2, 0xC3, 0xD4, 0xE5, 0xF6, 0x07.
  - `in_ready` drops to 0 after the 7th byte.
  - Second `feed_load` coincides with the edge leaving DONE; `feed_data` = 0xA1B2C3D4E5F607.
  - `feed_data` does not change before that load.
- Flush: send 0xDE, 0xAD, then pulse flush.
  - Expect `feed_data` = 0xDEAD0000000000 and the full 6-enable train.
  - flush with an empty pack produces no `feed_load`.
- Simultaneous flush and byte: bytes 0x01, 0x02, then 0x03 in the same cycle as flush.
  - Expect `feed_data` = 0x01020300000000.
- Reset mid-burst: assert reset=0 after the 3rd `feed_enable`.
  - All outputs go to 0 immediately (asynchronous); no `burst_done`.
  - After release, a fresh 7-byte burst behaves as in the single-burst scenario.
- Backpressure and GAP=0 (rebuild with GAP=0):
  - Enables occur on 6 consecutive cycles E2..E7; `burst_done` at E8.
  - in_valid held high with the pack full transfers nothing.

Source files
------------

// File: rtl/feeder_pkg.sv
// feeder_pkg: shared types and constants for the feeder_loader slice.
//   feeder_state_e : loader FSM states. The names carry an S_ prefix so that
//                    S_GAP does not collide with the GAP module parameter.
//   BYTE_W         : width of one input byte.
//   DEF_BYTES      : default bytes per burst.
//   BURST_W        : default burst word width (DEF_BYTES * BYTE_W).
package feeder_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEF_BYTES = 7;
  localparam int BURST_W   = DEF_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } feeder_state_e;

endpackage

// File: rtl/feeder_loader_if.sv
// feeder_loader_if: groups the byte-stream handshake and the data_feeder drive
// signals.
//   slave  : the loader's view. It receives in_valid/in_data/flush and drives
//            in_ready and the feed_* / busy / burst_done outputs.
//   master : the view of the producer/consumer environment.
interface feeder_loader_if #(
  parameter int BYTES = feeder_pkg::DEF_BYTES
);
  import feeder_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [BYTE_W-1:0]         in_data;
  logic                      flush;
  logic                      feed_load;
  logic [BYTES*BYTE_W-1:0]   feed_data;
  logic                      feed_enable;
  logic                      busy;
  logic                      burst_done;

  modport slave (
    input  in_valid, in_data, flush,
    output in_ready, feed_load, feed_data, feed_enable, busy, burst_done
  );

  modport master (
    output in_valid, in_data, flush,
    input  in_ready, feed_load, feed_data, feed_enable, busy, burst_done
  );

endinterface

// File: rtl/byte_packer.sv
// byte_packer: collects bytes MSB-first into a BYTES-wide pack register.
//   clk, reset : clock, asynchronous active-low reset
//   in_valid   : in_data holds a byte
//   in_data    : input byte
//   flush      : close a partial pack (the unfilled low bytes stay zero)
//   take       : the consumer copies the pack this cycle; clears it
//   in_ready   : pack_cnt < BYTES
//   full       : pack_cnt == BYTES
//   pack       : the pack contents
module byte_packer
  import feeder_pkg::*;
#(
  parameter int BYTES = DEF_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [BYTE_W-1:0]       in_data,
  input  logic                    flush,
  input  logic                    take,
  output logic                    in_ready,
  output logic                    full,
  output logic [BYTES*BYTE_W-1:0] pack
);

  localparam int DATA_W = BYTES * BYTE_W;
  localparam int CNT_W  = $clog2(BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES);

  logic [CNT_W-1:0] pack_cnt_reg;
  logic [CNT_W-1:0] cnt_after;
  logic             xfer;

  assign in_ready  = (pack_cnt_reg < CNT_FULL);
  assign full      = (pack_cnt_reg == CNT_FULL);
  assign xfer      = in_valid && in_ready;
  // The count including a byte transferring this cycle. Flush acts on this
  // value, so a byte that arrives together with flush is kept.
  assign cnt_after = pack_cnt_reg + CNT_W'(xfer);

  // take only arrives while the pack is full (in_ready = 0), so it can never
  // coincide with a transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pack_cnt_reg <= '0;
    end else if (take) begin
      pack_cnt_reg <= '0;
    end else if (flush && (cnt_after != '0) && (cnt_after < CNT_FULL)) begin
      pack_cnt_reg <= CNT_FULL;
    end else begin
      pack_cnt_reg <= cnt_after;
    end
  end

  // One register per byte slot. Slot gi holds the gi-th byte of the burst,
  // which sits at the top end of the word. Slots are cleared on take, so
  // flush padding needs no extra logic: unfilled slots are already zero.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_slot
    logic [BYTE_W-1:0] slot_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        slot_reg <= '0;
      end else if (take) begin
        slot_reg <= '0;
      end else if (xfer && (pack_cnt_reg == CNT_W'(gi))) begin
        slot_reg <= in_data;
      end
    end

    assign pack[DATA_W-1-gi*BYTE_W -: BYTE_W] = slot_reg;
  end

endmodule

// File: rtl/feeder_loader.sv
// feeder_loader: packs a byte stream into BYTES-byte bursts and drives
// data_feeder with a load pulse, the held burst word and a spaced train of
// shift enables. The next burst is packed while the current one is shifted.
//   clk, reset      : clock, asynchronous active-low reset
//   bus.in_valid    : in_data holds a byte
//   bus.in_ready    : the packer can accept a byte
//   bus.in_data     : input byte
//   bus.flush       : close a partial burst, zero padded
//   bus.feed_load   : one-cycle load pulse to data_feeder
//   bus.feed_data   : burst word, held from one load to the next
//   bus.feed_enable : shift enable, SHIFTS pulses, each followed by GAP idle cycles
//   bus.busy        : high in LOAD, SHIFT, GAP and DONE
//   bus.burst_done  : one-cycle pulse after the last shift's gap
module feeder_loader
  import feeder_pkg::*;
#(
  parameter int BYTES  = DEF_BYTES,
  parameter int SHIFTS = 6,
  parameter int GAP    = 1
) (
  input  logic            clk,
  input  logic            reset,
  feeder_loader_if.slave  bus
);

  localparam int DATA_W = BYTES * BYTE_W;
  localparam int SC_W   = $clog2(SHIFTS + 1);
  localparam logic [SC_W-1:0] SHIFTS_C = SC_W'(SHIFTS);
  // The gap counter counts down to zero, so it is loaded with GAP-1.
  localparam logic [3:0] GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  feeder_state_e     state_reg;
  logic [SC_W-1:0]   shift_cnt_reg;
  logic [SC_W-1:0]   shift_inc;
  logic [3:0]        gap_cnt_reg;
  logic [DATA_W-1:0] feed_data_reg;
  logic              feed_load_reg;
  logic              feed_enable_reg;
  logic              busy_reg;
  logic              burst_done_reg;

  logic              pack_full;
  logic [DATA_W-1:0] pack;
  logic              take;

  // The pack is copied out when the FSM is free for a new burst. That happens
  // in IDLE, or straight out of DONE when the next burst is already waiting.
  assign take      = pack_full && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign shift_inc = shift_cnt_reg + 1'b1;

  byte_packer #(
    .BYTES (BYTES)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .flush    (bus.flush),
    .take     (take),
    .in_ready (bus.in_ready),
    .full     (pack_full),
    .pack     (pack)
  );

  // The outputs are registered, so each branch sets the values the outputs
  // will hold during the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      shift_cnt_reg   <= '0;
      gap_cnt_reg     <= '0;
      feed_data_reg   <= '0;
      feed_load_reg   <= 1'b0;
      feed_enable_reg <= 1'b0;
      busy_reg        <= 1'b0;
      burst_done_reg  <= 1'b0;
    end else begin
      feed_load_reg   <= 1'b0;
      feed_enable_reg <= 1'b0;
      burst_done_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pack_full) begin
            feed_data_reg <= pack;
            feed_load_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= S_LOAD;
          end
        end
        S_LOAD: begin
          shift_cnt_reg   <= '0;
          feed_enable_reg <= 1'b1;
          state_reg       <= S_SHIFT;
        end
        S_SHIFT: begin
          shift_cnt_reg <= shift_inc;
          if (GAP > 0) begin
            gap_cnt_reg <= GAP_LAST;
            state_reg   <= S_GAP;
          end else if (shift_inc == SHIFTS_C) begin
            burst_done_reg <= 1'b1;
            state_reg      <= S_DONE;
          end else begin
            // With no gap, the enables run on consecutive cycles.
            feed_enable_reg <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end else if (shift_cnt_reg == SHIFTS_C) begin
            burst_done_reg <= 1'b1;
            state_reg      <= S_DONE;
          end else begin
            feed_enable_reg <= 1'b1;
            state_reg       <= S_SHIFT;
          end
        end
        S_DONE: begin
          if (pack_full) begin
            feed_data_reg <= pack;
            feed_load_reg <= 1'b1;
            state_reg     <= S_LOAD;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.feed_data   = feed_data_reg;
  assign bus.feed_load   = feed_load_reg;
  assign bus.feed_enable = feed_enable_reg;
  assign bus.busy        = busy_reg;
  assign bus.burst_done  = burst_done_reg;

endmodule

// File: tb/tb_feeder_loader.sv
// tb_feeder_loader: self-checking bench for feeder_loader. It builds two
// instances: dut (GAP=1) and dut_g0 (GAP=0), selected through sel. Expected
// words are assembled from the byte lists. The expected pulse timeline is
// computed from the latency rules relative to the edge E0 at which the pack
// becomes full.
module tb_feeder_loader;
  import feeder_pkg::*;

  localparam int S = 6;
  localparam int B = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  feeder_loader_if if1 ();
  feeder_loader_if if0 ();

  feeder_loader #(.BYTES(B), .SHIFTS(S), .GAP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  feeder_loader #(.BYTES(B), .SHIFTS(S), .GAP(0)) dut_g0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  int         sel = 0;
  logic       drv_valid = 1'b0;
  logic       drv_flush = 1'b0;
  logic [7:0] drv_data = 8'h00;

  assign if1.in_valid = drv_valid && (sel == 0);
  assign if0.in_valid = drv_valid && (sel == 1);
  assign if1.flush    = drv_flush && (sel == 0);
  assign if0.flush    = drv_flush && (sel == 1);
  assign if1.in_data  = drv_data;
  assign if0.in_data  = drv_data;

  int checks = 0;
  int errors = 0;
  byte unsigned nxt_q[$];

  function automatic logic rdy();
    return (sel == 1) ? if0.in_ready : if1.in_ready;
  endfunction

  // {feed_load, feed_enable, burst_done, busy}
  function automatic logic [3:0] obs();
    if (sel == 1) return {if0.feed_load, if0.feed_enable, if0.burst_done, if0.busy};
    return {if1.feed_load, if1.feed_enable, if1.burst_done, if1.busy};
  endfunction

  function automatic logic [55:0] fdata();
    return (sel == 1) ? if0.feed_data : if1.feed_data;
  endfunction

  function automatic int gap_of_sel();
    return (sel == 1) ? 0 : 1;
  endfunction

  // First byte is the most significant; missing bytes are zero padding.
  function automatic logic [55:0] pack_word(input byte unsigned b[$]);
    logic [55:0] w = '0;
    foreach (b[i]) w = w | (56'(b[i]) << (8 * (B - 1 - i)));
    return w;
  endfunction

  // Send bytes back to back. fmode: 0 = no flush, 1 = flush pulse after the
  // last byte, 2 = flush together with the last byte. Returns #1 after E0.
  task automatic send_burst(input byte unsigned b[$], input int fmode);
    foreach (b[i]) begin
      int t = 0;
      drv_valid = 1'b1;
      drv_data  = b[i];
      drv_flush = (fmode == 2) && (i == b.size() - 1);
      while (!rdy() && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for byte %0d", i);
      end
      @(posedge clk); #1;
    end
    drv_valid = 1'b0;
    drv_flush = 1'b0;
    if (fmode == 1) begin
      drv_flush = 1'b1;
      @(posedge clk); #1;
      drv_flush = 1'b0;
    end
  endtask

  // Walk the burst timeline from cycle c_start up to the edge that leaves
  // DONE. Bytes in nxt_q are offered whenever possible. next_word is the word
  // expected if a second burst gets loaded at the DONE exit.
  task automatic trace(input logic [55:0] word, input logic [55:0] next_word,
                       input int c_start, input string tag);
    int g = gap_of_sel();
    int ndone = 2 + S * (1 + g);
    int sent = 0;
    for (int c = c_start; c <= ndone + 1; c++) begin
      logic pre_valid, pre_ready, chain_pre;
      logic [3:0] e, o;
      logic [55:0] ew;
      if (nxt_q.size() > 0) begin
        drv_valid = 1'b1;
        drv_data  = nxt_q[0];
      end else begin
        drv_valid = 1'b0;
      end
      pre_valid = drv_valid;
      pre_ready = rdy();
      chain_pre = (sent >= B);
      @(posedge clk); #1;
      if (pre_valid && pre_ready) begin
        void'(nxt_q.pop_front());
        sent++;
        if (sent == B) begin
          checks++;
          if (rdy() !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_after_7th c=%0d: got %b want 0", tag, c, rdy());
          end
        end
      end
      e[3] = (c == 1) || ((c == ndone + 1) && chain_pre);
      e[2] = (c >= 2) && ((c - 2) % (1 + g) == 0) && ((c - 2) / (1 + g) < S);
      e[1] = (c == ndone);
      e[0] = (c <= ndone) || chain_pre;
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s timeline c=%0d: got {load,en,done,busy}=%b want %b", tag, c, o, e);
      end
      ew = ((c == ndone + 1) && chain_pre) ? next_word : word;
      checks++;
      if (fdata() !== ew) begin
        errors++;
        $display("FAIL %s feed_data c=%0d: got %h want %h", tag, c, fdata(), ew);
      end
    end
    drv_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      checks++;
      if (obs() !== 4'b0000 || fdata() !== '0 || rdy() !== 1'b1) begin
        errors++;
        $display("FAIL reset_state sel=%0d: got outs=%b data=%h ready=%b want 0000/0/1",
                 s, obs(), fdata(), rdy());
      end
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_burst();
    byte unsigned b[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    sel = 0;
    send_burst(b, 0);
    trace(56'h11223344556677, '0, 1, "single");
  endtask

  task automatic test_overlap();
    byte unsigned b[$] = '{8'h5A, 8'h3C, 8'h81, 8'h00, 8'hFF, 8'h42, 8'h99};
    sel = 0;
    nxt_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07};
    send_burst(b, 0);
    trace(pack_word(b), 56'hA1B2C3D4E5F607, 1, "overlap1");
    trace(56'hA1B2C3D4E5F607, '0, 2, "overlap2");
  endtask

  task automatic test_flush();
    byte unsigned b[$] = '{8'hDE, 8'hAD};
    byte unsigned e[$];
    sel = 0;
    send_burst(b, 1);
    trace(56'hDEAD0000000000, '0, 1, "flush");
    begin
      int loads = 0;
      send_burst(e, 1);
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (obs()[3]) loads++;
      end
      checks++;
      if (loads !== 0 || rdy() !== 1'b1) begin
        errors++;
        $display("FAIL flush_empty: got loads=%0d ready=%b want 0/1", loads, rdy());
      end
    end
  endtask

  task automatic test_flush_with_byte();
    byte unsigned b[$] = '{8'h01, 8'h02, 8'h03};
    sel = 0;
    send_burst(b, 2);
    trace(56'h01020300000000, '0, 1, "flush_byte");
  endtask

  task automatic test_reset_mid_burst();
    byte unsigned b[$];
    int n = 0;
    int t = 0;
    sel = 0;
    for (int i = 0; i < B; i++) b.push_back(8'($urandom));
    send_burst(b, 0);
    while (n < 3 && t < 100) begin
      @(posedge clk); #1;
      if (obs()[2]) n++;
      t++;
    end
    checks++;
    if (n < 3) begin
      errors++;
      $display("FAIL reset_mid wait: got %0d enables want 3", n);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 4'b0000 || fdata() !== '0 || rdy() !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid async: got outs=%b data=%h ready=%b want 0000/0/1",
               obs(), fdata(), rdy());
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid held: got outs=%b want 0000", obs());
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    send_burst(b, 0);
    trace(56'h11223344556677, '0, 1, "after_reset");
  endtask

  task automatic test_gap0_backpressure();
    byte unsigned b[$];
    byte unsigned nb[$];
    sel = 1;
    for (int i = 0; i < B; i++) b.push_back(8'($urandom));
    for (int i = 0; i < B; i++) nb.push_back(8'($urandom));
    nxt_q = nb;
    nxt_q.push_back(8'hEE);  // held valid while the pack is full
    send_burst(b, 0);
    trace(pack_word(b), pack_word(nb), 1, "gap0_a");
    checks++;
    if (nxt_q.size() !== 1) begin
      errors++;
      $display("FAIL gap0 backpressure: got %0d bytes left want 1", nxt_q.size());
    end
    nxt_q.delete();
    trace(pack_word(nb), '0, 2, "gap0_b");
  endtask

  task automatic test_random_bursts();
    for (int r = 0; r < 8; r++) begin
      byte unsigned b[$];
      int n = $urandom_range(1, B);
      int fm = (n < B) ? $urandom_range(1, 2) : 0;
      sel = r % 2;
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      send_burst(b, fm);
      trace(pack_word(b), '0, 1, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_burst();
    test_overlap();
    test_flush();
    test_flush_with_byte();
    test_reset_mid_burst();
    test_gap0_backpressure();
    test_random_bursts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
